// File: rtl/count_ones_rr_scheduler.sv
// count_ones_rr_scheduler: round-robin sharing of one count_ones unit among NUM_REQ requesters.
// Latency: grant to resp_valid takes 3 cycles plus the cycles spent waiting for cu_done in BUSY.
// Backpressure: req_ready pulses only in IDLE; requesters hold valid/data until their grant.
// Optional watchdog: define COUNT_ONES_RR_TIMEOUT_EN to bound BUSY to TIMEOUT_CYC cycles (resp_err).
module count_ones_rr_scheduler #(
  parameter  int NUM_REQ      = 4,
  parameter  int INPUT_WIDTH  = 32,
  parameter  int TIMEOUT_CYC  = 1024,
  localparam int OUTPUT_WIDTH = $clog2(INPUT_WIDTH + 1),
  localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           resp_valid,
  output logic [ID_WIDTH-1:0]            resp_id,
  output logic [OUTPUT_WIDTH-1:0]        resp_count,
  output logic                           resp_err,
  output logic                           cu_go,
  output logic [INPUT_WIDTH-1:0]         cu_in,
  input  logic [OUTPUT_WIDTH-1:0]        cu_out,
  input  logic                           cu_done
);

  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, BUSY, RESP} state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     id_reg;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic [ID_WIDTH-1:0]     cand;
  logic [ID_WIDTH-1:0]     next_ptr;
  logic                    grant_any;
  logic [INPUT_WIDTH-1:0]  operand;
  logic [INPUT_WIDTH-1:0]  grant_data;

  if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("count_ones_rr_scheduler: needs NUM_REQ >= 2 and TIMEOUT_CYC >= 1");
  end

`ifdef COUNT_ONES_RR_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYC + 1);
  logic [WD_WIDTH-1:0] wd_cnt;
`else
  assign resp_err = 1'b0;
`endif

  // Round-robin pick: scan offsets high to low so the nearest set bit at/after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the winner's operand slice.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) grant_data = req_data[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  // Accept pulse in the grant cycle; forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst && state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign cu_in    = operand;

  // Job sequencer: grant, launch, settle, wait for done, respond; all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_reg     <= '0;
      operand    <= '0;
      cu_go      <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_count <= '0;
`ifdef COUNT_ONES_RR_TIMEOUT_EN
      resp_err   <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      cu_go      <= 1'b0;
      resp_valid <= 1'b0;
`ifdef COUNT_ONES_RR_TIMEOUT_EN
      resp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_any) begin
            operand <= grant_data;
            id_reg  <= grant_idx;
            rr_ptr  <= next_ptr;
            cu_go   <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: state <= SETTLE;
        SETTLE: begin
          // cu_done may still reflect the previous job here, so it is not looked at.
`ifdef COUNT_ONES_RR_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= BUSY;
        end
        BUSY: begin
          if (cu_done) begin
            resp_valid <= 1'b1;
            resp_id    <= id_reg;
            resp_count <= cu_out;
            state      <= RESP;
          end
`ifdef COUNT_ONES_RR_TIMEOUT_EN
          else if (wd_cnt == WD_WIDTH'(TIMEOUT_CYC - 1)) begin
            resp_valid <= 1'b1;
            resp_id    <= id_reg;
            resp_count <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_ones_rr_scheduler.sv
// Bench for count_ones_rr_scheduler: directed scenarios plus randomized jobs.
// A behavioural count_ones stand-in answers cu_go after a chosen latency.
// Expected grants and counts come from a simple round-robin and popcount model.
module tb_count_ones_rr_scheduler;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int OW = 6;
  localparam int IW = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic [OW-1:0]   resp_count;
  logic            resp_err;
  logic            cu_go;
  logic [W-1:0]    cu_in;
  logic [OW-1:0]   cu_out;
  logic            cu_done;
  logic [W-1:0]    dat [N];

  int n_cmp = 0;
  int n_bad = 0;
  int rr_m = 0;
  int lat_cfg = 1;
  bit stuck = 1'b0;
  bit watch1 = 1'b0;
  int watch_hits = 0;
  int m_cnt = 0;
  bit m_skip = 1'b0;
  logic [W-1:0] m_op;

  for (genvar gi = 0; gi < N; gi++) begin : g_data
    assign req_data[gi*W +: W] = dat[gi];
  end

  count_ones_rr_scheduler #(.NUM_REQ(N), .INPUT_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_count(resp_count), .resp_err(resp_err),
    .cu_go(cu_go), .cu_in(cu_in), .cu_out(cu_out), .cu_done(cu_done));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  function automatic int ones(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int pick(input logic [N-1:0] m, input int rr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_data();
    case ($urandom_range(3, 0))
      0:       return '0;
      1:       return '1;
      default: return $urandom;
    endcase
  endfunction

  // Behavioural count_ones: after cu_go, leaves its old done/result untouched for one
  // more cycle, then reports popcount after lat_cfg further cycles and holds it.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      cu_done = 1'b0; cu_out = '0; m_cnt = 0; m_skip = 1'b0; m_op = '0;
    end else if (cu_go) begin
      m_op = cu_in; m_cnt = lat_cfg; m_skip = 1'b1;
    end else if (m_skip) begin
      m_skip = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && !stuck) begin
        cu_done = 1'b1; cu_out = OW'(ones(m_op));
      end else begin
        cu_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (watch1 && (req_ready[1] || (resp_valid && resp_id == IW'(1)))) watch_hits++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    rr_m = 0;
  endtask

  // Serve one job: wait for grant, follow it to the response and check everything on the way.
  task automatic serve(input int exp_g_in, input int lat, input bit exp_to,
                       input logic [N-1:0] pulse, input int exp_wait);
    int w, n, gos, g, exp_n;
    logic [W-1:0] op;
    lat_cfg = lat;
    #1;
    w = 0;
    while (req_ready == '0 && w < 60) begin step(); w++; end
    g = (exp_g_in >= 0) ? exp_g_in : pick(req_valid, rr_m);
    check("grant", req_ready, 64'h1 << g);
    if (req_ready == '0) return;
    if (exp_wait >= 0) check("b2b_wait", w, exp_wait);
    op = dat[g];
    rr_m = (g + 1) % N;
    step();
    req_valid[g] = 1'b0;
    check("ready_low_launch", req_ready, 0);
    n = 1;
    gos = 0;
    while (!resp_valid && n < 60) begin
      if (cu_go) gos++;
      check("cu_in_stable", cu_in, op);
      if (n == 2) req_valid = req_valid | pulse;
      if (n == 4) req_valid = req_valid & ~pulse;
      step();
      n++;
    end
    exp_n = exp_to ? 3 + TO : 3 + lat;
    check("resp_latency", n, exp_n);
    check("go_pulses", gos, 1);
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, g);
    check("resp_count", resp_count, exp_to ? 0 : ones(op));
    check("resp_err", resp_err, exp_to);
    step();
    check("resp_pulse_end", resp_valid, 0);
    check("resp_id_hold", resp_id, g);
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = $urandom | 32'h1;
    // Reset state, with every requester asking.
    req_valid = '1;
    step(); step();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_count", resp_count, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_cu_go", cu_go, 0);
    check("rst_cu_in", cu_in, 0);
    req_valid = '0;
    rst = 1'b1;
    rr_m = 0;

    // Single requester 2 with all ones.
    dat[2] = 32'hFFFF_FFFF;
    req_valid = 4'b0100;
    serve(2, 2, 1'b0, '0, -1);

    // All four holding: strict rotation, back-to-back grants.
    do_reset();
    dat[0] = 32'd0; dat[1] = 32'd1; dat[2] = 32'd3; dat[3] = 32'd7;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(i % N, 1 + i % 3, 1'b0, '0, (i == 0) ? -1 : 0);
      if (i < 4) req_valid[i % N] = 1'b1;
      else req_valid = '0;
    end

    // Zero operand, then two bits set while the old done is still high in SETTLE.
    dat[1] = 32'h0;
    req_valid = 4'b0010;
    serve(-1, 2, 1'b0, '0, -1);
    dat[2] = 32'h8000_0001;
    req_valid = 4'b0100;
    serve(-1, 3, 1'b0, '0, -1);

    // Asynchronous reset in the middle of BUSY.
    lat_cfg = 30;
    dat[2] = 32'hA5A5_0F0F;
    req_valid = 4'b0100;
    #1;
    begin
      int w4 = 0;
      while (req_ready == '0 && w4 < 60) begin step(); w4++; end
    end
    check("t4_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'b1010;
    repeat (4) step();
    check("t4_busy_no_resp", resp_valid, 0);
    rst = 1'b0;
    #1;
    check("t4_req_ready", req_ready, 0);
    check("t4_resp_valid", resp_valid, 0);
    check("t4_resp_id", resp_id, 0);
    check("t4_resp_count", resp_count, 0);
    check("t4_resp_err", resp_err, 0);
    check("t4_cu_go", cu_go, 0);
    check("t4_cu_in", cu_in, 0);
    repeat (3) begin
      step();
      check("t4_no_resp_in_rst", resp_valid, 0);
    end
    rst = 1'b1;
    rr_m = 0;
    serve(1, 2, 1'b0, '0, -1);

    // Requester 1 pulses while busy and drops out: never served.
    watch1 = 1'b1;
    dat[0] = rand_data();
    req_valid = 4'b0001;
    serve(0, 3, 1'b0, 4'b0010, -1);
    dat[3] = rand_data();
    req_valid[3] = 1'b1;
    serve(3, 2, 1'b0, '0, -1);
    watch1 = 1'b0;
    check("dropped_req1_hits", watch_hits, 0);

    // Randomized jobs against the round-robin model.
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          dat[i] = rand_data();
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        dat[j % N] = rand_data();
        req_valid[j % N] = 1'b1;
      end
      serve(-1, $urandom_range(5, 1), 1'b0, '0, -1);
    end
    req_valid = '0;

`ifdef COUNT_ONES_RR_TIMEOUT_EN
    // Watchdog: cu_done never rises.
    stuck = 1'b1;
    dat[2] = 32'hFFFF_0000;
    req_valid = 4'b0100;
    serve(-1, 1, 1'b1, '0, -1);
    stuck = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
